wave_analyzer: RTL and testbench



---
 rtl/wave_pkg.sv | 16 +
 rtl/wave_analyzer_if.sv | 27 ++
 rtl/wave_hyst_cmp.sv | 20 ++
 rtl/wave_analyzer.sv | 157 +++++++++++++++
 tb/tb_wave_analyzer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wave_pkg.sv
// Shared types and defaults for waveform measurement blocks.
// Sample codes are 8-bit unsigned; MID/HYST defaults match the wave sources' full-scale swing.
package wave_pkg;

  localparam int SAMPLE_W = 8;
  localparam int MID_DEF  = 128;
  localparam int HYST_DEF = 8;

  typedef enum logic [1:0] {
    START  = 2'd0,
    ARM    = 2'd1,
    RUN_HI = 2'd2,
    RUN_LO = 2'd3
  } state_t;

endpackage

// File: rtl/wave_analyzer_if.sv
// Sample stream in, period/peak/trough measurement out; master is the wave source side.
// No ready signal: every cycle with sample_valid=1 is consumed.
interface wave_analyzer_if #(
  parameter int CNT_W = 16
);

  logic                          sample_valid;
  logic [wave_pkg::SAMPLE_W-1:0] sample;
  logic                          clear;
  logic [CNT_W-1:0]              period;
  logic [wave_pkg::SAMPLE_W-1:0] max_val;
  logic [wave_pkg::SAMPLE_W-1:0] min_val;
  logic                          meas_valid;
  logic                          locked;
  logic                          timeout;

  modport master (
    output sample_valid, sample, clear,
    input  period, max_val, min_val, meas_valid, locked, timeout
  );

  modport slave (
    input  sample_valid, sample, clear,
    output period, max_val, min_val, meas_valid, locked, timeout
  );

endinterface

// File: rtl/wave_hyst_cmp.sv
// Classifies a sample against a hysteresis band around MID: hi at/above MID+HYST, lo at/below MID-HYST.
// Purely combinational, zero latency; in-band samples assert neither flag.
module wave_hyst_cmp
  import wave_pkg::*;
#(
  parameter int MID  = MID_DEF,
  parameter int HYST = HYST_DEF
) (
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic                o_hi,
  output logic                o_lo
);

  localparam logic [SAMPLE_W-1:0] HI_TH = SAMPLE_W'(MID + HYST);
  localparam logic [SAMPLE_W-1:0] LO_TH = SAMPLE_W'(MID - HYST);

  assign o_hi = (i_sample >= HI_TH);
  assign o_lo = (i_sample <= LO_TH);

endmodule

// File: rtl/wave_analyzer.sv
// Measures period, peak and trough between rising hysteresis crossings; outputs registered, meas_valid one cycle after the crossing sample.
// No backpressure: idle cycles (sample_valid=0) hold all state; clear restarts synchronously and outranks sample_valid.
module wave_analyzer
  import wave_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int MID   = MID_DEF,
  parameter int HYST  = HYST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  wave_analyzer_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                r_state,  w_state_nxt;
  logic [CNT_W-1:0]      r_cnt,    w_cnt_nxt;
  logic [SAMPLE_W-1:0]   r_run_max, w_run_max_nxt;
  logic [SAMPLE_W-1:0]   r_run_min, w_run_min_nxt;
  logic [CNT_W-1:0]      r_period, w_period_nxt;
  logic [SAMPLE_W-1:0]   r_max_val, w_max_val_nxt;
  logic [SAMPLE_W-1:0]   r_min_val, w_min_val_nxt;
  logic                  r_meas_valid, w_meas_valid_nxt;
  logic                  r_locked, w_locked_nxt;
  logic                  r_timeout, w_timeout_nxt;

  logic                  w_hi;
  logic                  w_lo;
  logic                  w_sat;
  logic [SAMPLE_W-1:0]   w_max_upd;
  logic [SAMPLE_W-1:0]   w_min_upd;

  wave_hyst_cmp #(
    .MID  (MID),
    .HYST (HYST)
  ) u_cmp (
    .i_sample (bus.sample),
    .o_hi     (w_hi),
    .o_lo     (w_lo)
  );

  assign w_sat     = &r_cnt;
  assign w_max_upd = (bus.sample > r_run_max) ? bus.sample : r_run_max;
  assign w_min_upd = (bus.sample < r_run_min) ? bus.sample : r_run_min;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= START;
      r_cnt        <= '0;
      r_run_max    <= '0;
      r_run_min    <= '1;
      r_period     <= '0;
      r_max_val    <= '0;
      r_min_val    <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_run_max    <= w_run_max_nxt;
      r_run_min    <= w_run_min_nxt;
      r_period     <= w_period_nxt;
      r_max_val    <= w_max_val_nxt;
      r_min_val    <= w_min_val_nxt;
      r_meas_valid <= w_meas_valid_nxt;
      r_locked     <= w_locked_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_run_max_nxt    = r_run_max;
    w_run_min_nxt    = r_run_min;
    w_period_nxt     = r_period;
    w_max_val_nxt    = r_max_val;
    w_min_val_nxt    = r_min_val;
    w_meas_valid_nxt = 1'b0;
    w_locked_nxt     = r_locked;
    w_timeout_nxt    = r_timeout;

    if (bus.clear) begin
      w_state_nxt   = START;
      w_cnt_nxt     = '0;
      w_run_max_nxt = '0;
      w_run_min_nxt = '1;
      w_period_nxt  = '0;
      w_max_val_nxt = '0;
      w_min_val_nxt = '0;
      w_locked_nxt  = 1'b0;
      w_timeout_nxt = 1'b0;
    end else if (bus.sample_valid) begin
      unique case (r_state)
        START: begin
          if (w_lo) w_state_nxt = ARM;
        end
        ARM: begin
          if (w_hi) begin
            w_state_nxt   = RUN_HI;
            w_cnt_nxt     = CNT_ONE;
            w_run_max_nxt = bus.sample;
            w_run_min_nxt = bus.sample;
          end
        end
        RUN_HI: begin
          if (w_sat) begin
            w_state_nxt   = START;
            w_cnt_nxt     = '0;
            w_timeout_nxt = 1'b1;
            w_locked_nxt  = 1'b0;
          end else begin
            w_cnt_nxt     = r_cnt + CNT_ONE;
            w_run_max_nxt = w_max_upd;
            w_run_min_nxt = w_min_upd;
            if (w_lo) w_state_nxt = RUN_LO;
          end
        end
        RUN_LO: begin
          // A crossing wins over saturation: the window closed exactly at full count.
          if (w_hi) begin
            w_period_nxt     = r_cnt;
            w_max_val_nxt    = r_run_max;
            w_min_val_nxt    = r_run_min;
            w_cnt_nxt        = CNT_ONE;
            w_run_max_nxt    = bus.sample;
            w_run_min_nxt    = bus.sample;
            w_meas_valid_nxt = 1'b1;
            w_locked_nxt     = 1'b1;
            w_timeout_nxt    = 1'b0;
            w_state_nxt      = RUN_HI;
          end else if (w_sat) begin
            w_state_nxt   = START;
            w_cnt_nxt     = '0;
            w_timeout_nxt = 1'b1;
            w_locked_nxt  = 1'b0;
          end else begin
            w_cnt_nxt     = r_cnt + CNT_ONE;
            w_run_max_nxt = w_max_upd;
            w_run_min_nxt = w_min_upd;
          end
        end
        default: w_state_nxt = START;
      endcase
    end
  end

  assign bus.period     = r_period;
  assign bus.max_val    = r_max_val;
  assign bus.min_val    = r_min_val;
  assign bus.meas_valid = r_meas_valid;
  assign bus.locked     = r_locked;
  assign bus.timeout    = r_timeout;

endmodule

// File: tb/tb_wave_analyzer.sv
// Directed bench for wave_analyzer: square, band-only, saturation (CNT_W=4), triangle, gapped, clear and async reset.
module tb_wave_analyzer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wave_analyzer_if #(.CNT_W(16)) bus  ();
  wave_analyzer_if #(.CNT_W(4))  bus4 ();

  wave_analyzer #(.CNT_W(16), .MID(128), .HYST(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wave_analyzer #(.CNT_W(4), .MID(128), .HYST(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  task automatic drive(input logic v, input logic [7:0] s);
    bus.sample_valid = v;
    bus.sample       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic v, input logic [7:0] s);
    bus4.sample_valid = v;
    bus4.sample       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.sample_valid  = 1'b0;
    bus.sample        = 8'd0;
    bus.clear         = 1'b0;
    bus4.sample_valid = 1'b0;
    bus4.sample       = 8'd0;
    bus4.clear        = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.period !== 16'd0)   begin errors++; $display("FAIL rst_period got %0d exp 0", bus.period); end
    checks++; if (bus.max_val !== 8'd0)   begin errors++; $display("FAIL rst_max got %0d exp 0", bus.max_val); end
    checks++; if (bus.min_val !== 8'd0)   begin errors++; $display("FAIL rst_min got %0d exp 0", bus.min_val); end
    checks++; if (bus.meas_valid !== 1'b0) begin errors++; $display("FAIL rst_mv got %b exp 0", bus.meas_valid); end
    checks++; if (bus.locked !== 1'b0)    begin errors++; $display("FAIL rst_locked got %b exp 0", bus.locked); end
    checks++; if (bus.timeout !== 1'b0)   begin errors++; $display("FAIL rst_timeout got %b exp 0", bus.timeout); end
  endtask

  task automatic test_square();
    logic exp_mv;
    do_reset();
    drive(1'b1, 8'd0);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, (i < 4) ? 8'd255 : 8'd0);
        exp_mv = (p > 0 && i == 0);
        checks++;
        if (bus.meas_valid !== exp_mv) begin
          errors++; $display("FAIL sq_mv p=%0d i=%0d got %b exp %b", p, i, bus.meas_valid, exp_mv);
        end
        if (exp_mv) begin
          checks++; if (bus.period !== 16'd8)   begin errors++; $display("FAIL sq_period got %0d exp 8", bus.period); end
          checks++; if (bus.max_val !== 8'd255) begin errors++; $display("FAIL sq_max got %0d exp 255", bus.max_val); end
          checks++; if (bus.min_val !== 8'd0)   begin errors++; $display("FAIL sq_min got %0d exp 0", bus.min_val); end
          checks++; if (bus.locked !== 1'b1)    begin errors++; $display("FAIL sq_locked got %b exp 1", bus.locked); end
        end
      end
    end
  endtask

  task automatic test_band();
    int mv_seen = 0;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, 8'(121 + (i % 15)));
      if (bus.meas_valid === 1'b1) mv_seen++;
    end
    checks++; if (mv_seen !== 0)        begin errors++; $display("FAIL band_mv got %0d pulses exp 0", mv_seen); end
    checks++; if (bus.locked !== 1'b0)  begin errors++; $display("FAIL band_locked got %b exp 0", bus.locked); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL band_timeout got %b exp 0", bus.timeout); end
  endtask

  task automatic test_timeout();
    do_reset();
    // 0,255,255,0,0,255 -> one measurement of period 4
    drive4(1'b1, 8'd0);
    drive4(1'b1, 8'd255);
    drive4(1'b1, 8'd255);
    drive4(1'b1, 8'd0);
    drive4(1'b1, 8'd0);
    drive4(1'b1, 8'd255);
    checks++; if (bus4.meas_valid !== 1'b1) begin errors++; $display("FAIL to_mv1 got %b exp 1", bus4.meas_valid); end
    checks++; if (bus4.period !== 4'd4)     begin errors++; $display("FAIL to_period1 got %0d exp 4", bus4.period); end
    // crossing sample was count 1; 14 more reach 15 (all-ones)
    for (int i = 0; i < 14; i++) drive4(1'b1, 8'd200);
    checks++; if (bus4.timeout !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", bus4.timeout); end
    checks++; if (bus4.locked !== 1'b1)  begin errors++; $display("FAIL to_early_lock got %b exp 1", bus4.locked); end
    drive4(1'b1, 8'd200);
    checks++; if (bus4.timeout !== 1'b1)    begin errors++; $display("FAIL to_set got %b exp 1", bus4.timeout); end
    checks++; if (bus4.locked !== 1'b0)     begin errors++; $display("FAIL to_unlock got %b exp 0", bus4.locked); end
    checks++; if (bus4.period !== 4'd4)     begin errors++; $display("FAIL to_period_hold got %0d exp 4", bus4.period); end
    checks++; if (bus4.max_val !== 8'd255)  begin errors++; $display("FAIL to_max_hold got %0d exp 255", bus4.max_val); end
    checks++; if (bus4.meas_valid !== 1'b0) begin errors++; $display("FAIL to_mv0 got %b exp 0", bus4.meas_valid); end
    drive4(1'b1, 8'd128);
    drive4(1'b1, 8'd200);
    checks++; if (bus4.timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", bus4.timeout); end
    // restart from START: 0 arms, 255 runs, crossing after 4
    drive4(1'b1, 8'd0);
    drive4(1'b1, 8'd255);
    drive4(1'b1, 8'd255);
    drive4(1'b1, 8'd0);
    drive4(1'b1, 8'd0);
    checks++; if (bus4.timeout !== 1'b1) begin errors++; $display("FAIL to_sticky2 got %b exp 1", bus4.timeout); end
    drive4(1'b1, 8'd255);
    checks++; if (bus4.meas_valid !== 1'b1) begin errors++; $display("FAIL to_mv2 got %b exp 1", bus4.meas_valid); end
    checks++; if (bus4.period !== 4'd4)     begin errors++; $display("FAIL to_period2 got %0d exp 4", bus4.period); end
    checks++; if (bus4.timeout !== 1'b0)    begin errors++; $display("FAIL to_clr got %b exp 0", bus4.timeout); end
    checks++; if (bus4.locked !== 1'b1)     begin errors++; $display("FAIL to_relock got %b exp 1", bus4.locked); end
  endtask

  task automatic test_triangle();
    logic [7:0] tri_wave [126];
    logic exp_mv;
    for (int i = 0; i < 64; i++) tri_wave[i] = 8'(4 * i);
    for (int i = 1; i < 63; i++) tri_wave[63 + i] = 8'(252 - 4 * i);
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 126; i++) begin
        drive(1'b1, tri_wave[i]);
        exp_mv = (r > 0 && i == 34);
        checks++;
        if (bus.meas_valid !== exp_mv) begin
          errors++; $display("FAIL tri_mv r=%0d i=%0d got %b exp %b", r, i, bus.meas_valid, exp_mv);
        end
        if (exp_mv) begin
          checks++; if (bus.period !== 16'd126) begin errors++; $display("FAIL tri_period got %0d exp 126", bus.period); end
          checks++; if (bus.max_val !== 8'd252) begin errors++; $display("FAIL tri_max got %0d exp 252", bus.max_val); end
          checks++; if (bus.min_val !== 8'd0)   begin errors++; $display("FAIL tri_min got %0d exp 0", bus.min_val); end
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic        exp_mv;
    logic [15:0] exp_period;
    do_reset();
    drive(1'b1, 8'd0);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, (i < 4) ? 8'd255 : 8'd0);
        exp_mv     = (p > 0 && i == 0);
        exp_period = (p > 0) ? 16'd8 : 16'd0;
        checks++;
        if (bus.meas_valid !== exp_mv) begin
          errors++; $display("FAIL gap_mv p=%0d i=%0d got %b exp %b", p, i, bus.meas_valid, exp_mv);
        end
        for (int g = 0; g < 3; g++) begin
          drive(1'b0, 8'd255);
          checks++;
          if (bus.meas_valid !== 1'b0) begin
            errors++; $display("FAIL gap_mv_idle p=%0d i=%0d got %b exp 0", p, i, bus.meas_valid);
          end
          checks++;
          if (bus.period !== exp_period) begin
            errors++; $display("FAIL gap_period p=%0d i=%0d got %0d exp %0d", p, i, bus.period, exp_period);
          end
        end
      end
    end
  endtask

  task automatic test_clear_rst();
    logic exp_mv;
    logic [7:0] seq [9] = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd255};
    do_reset();
    drive(1'b1, 8'd0);
    for (int i = 0; i < 8; i++) drive(1'b1, (i < 4) ? 8'd255 : 8'd0);
    drive(1'b1, 8'd255);
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL clr_pre_lock got %b exp 1", bus.locked); end
    for (int i = 1; i < 8; i++) drive(1'b1, (i < 4) ? 8'd255 : 8'd0);
    bus.clear = 1'b1;
    drive(1'b1, 8'd255);
    bus.clear = 1'b0;
    checks++; if (bus.meas_valid !== 1'b0) begin errors++; $display("FAIL clr_mv got %b exp 0", bus.meas_valid); end
    checks++; if (bus.period !== 16'd0)    begin errors++; $display("FAIL clr_period got %0d exp 0", bus.period); end
    checks++; if (bus.max_val !== 8'd0)    begin errors++; $display("FAIL clr_max got %0d exp 0", bus.max_val); end
    checks++; if (bus.min_val !== 8'd0)    begin errors++; $display("FAIL clr_min got %0d exp 0", bus.min_val); end
    checks++; if (bus.locked !== 1'b0)     begin errors++; $display("FAIL clr_locked got %b exp 0", bus.locked); end
    checks++; if (bus.timeout !== 1'b0)    begin errors++; $display("FAIL clr_timeout got %b exp 0", bus.timeout); end
    // From START: leading 255s ignored, 0 arms, then a period of 4
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, seq[i]);
      exp_mv = (i == 8);
      checks++;
      if (bus.meas_valid !== exp_mv) begin
        errors++; $display("FAIL clr_restart_mv i=%0d got %b exp %b", i, bus.meas_valid, exp_mv);
      end
    end
    checks++; if (bus.period !== 16'd4) begin errors++; $display("FAIL clr_restart_period got %0d exp 4", bus.period); end
    drive(1'b1, 8'd255);
    drive(1'b1, 8'd0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.period !== 16'd0)  begin errors++; $display("FAIL arst_period got %0d exp 0", bus.period); end
    checks++; if (bus.max_val !== 8'd0)  begin errors++; $display("FAIL arst_max got %0d exp 0", bus.max_val); end
    checks++; if (bus.min_val !== 8'd0)  begin errors++; $display("FAIL arst_min got %0d exp 0", bus.min_val); end
    checks++; if (bus.locked !== 1'b0)   begin errors++; $display("FAIL arst_locked got %b exp 0", bus.locked); end
    checks++; if (bus.timeout !== 1'b0)  begin errors++; $display("FAIL arst_timeout got %b exp 0", bus.timeout); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_square();
    test_band();
    test_timeout();
    test_triangle();
    test_gaps();
    test_clear_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
